truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequences characterisation of one 3-input logic function (e.g. m0x0C) by driving all 8 input rows in order.
//  For each row: wait a settle time, then sample the function output. Collects an 8-bit Wolfram-coded
//  truth table, compares it with an expected code, and flags rows whose output changed while sampling.
//  Sits between a test/config host (start/expected/results) and the combinational function under test.
// PARAMETERS
//  SETTLE_CYCLES  8  cycles a row is held before sampling starts; legal range 3..255 (covers the 2-flop sync)
//  SAMPLE_CYCLES  2  consecutive samples taken per row; legal range 1..15
// PORTS
//  clk            in   1  single clock; all state changes on the rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  start          in   1  sweep request; accepted only in IDLE
//  abort          in   1  cancels an in-progress sweep
//  expected       in   8  expected Wolfram code; latched when start is accepted
//  in1,in2,in3    out  1  row drive to the function under test
//  dut_out        in   1  function output; asynchronous to clk
//  busy           out  1  high from the cycle after start is accepted until the DONE cycle
//  done           out  1  1-cycle pulse; results are valid from this cycle
//  aborted        out  1  1-cycle pulse when an abort is taken
//  measured       out  8  captured Wolfram code
//  mismatch_mask  out  8  measured ^ expected_q; valid with done
//  unstable       out  8  per-bit flag: samples disagreed within that row
//  match          out  1  (measured==expected_q) && (unstable==0); valid with done
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; row=0; counters=0; expected_q=0.
//  Row coding: row r = {in1,in2,in3}. Its result goes to bit [7-r]. Example: m0x0C captures 8'h0C.
//  States: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE:   in pins = 3'b000.
//           start=1 -> expected_q<=expected; measured, unstable, mismatch_mask, match <= 0; row<=0; cnt<=0; go SETTLE.
//   SETTLE: drive row on the in pins; cnt++.
//           When cnt==SETTLE_CYCLES-1 -> cnt<=0; go SAMPLE.
//   SAMPLE: keep driving row; read s = synchronised dut_out each cycle.
//           First sample -> measured[7-row]. Any later sample differing from it -> unstable[7-row]<=1.
//           Last sample (cnt==SAMPLE_CYCLES-1): row==7 -> go DONE; else row++, cnt<=0, go SETTLE.
//   DONE:   in pins = 000; done=1 for this cycle; write mismatch_mask and match; go IDLE.
//  Latency: start accepted at edge T -> done high in cycle T + 8*(SETTLE_CYCLES+SAMPLE_CYCLES) + 1.
//  dut_out passes through a 2-flop synchroniser; its delay is absorbed by SETTLE_CYCLES >= 3.
//  start while busy: ignored, no queueing. start and abort together in IDLE: start wins.
//  abort in SETTLE or SAMPLE: next cycle is IDLE, in pins 000, aborted pulses, done stays 0.
//   measured and unstable keep their partial contents; match stays 0.
//  abort in the DONE cycle: ignored; the sweep completes normally.
//  Changes to expected during a sweep are ignored; only expected_q is used.
//  Async reset mid-sweep: immediate return to the reset values; no done, no aborted.
//  Widths: row is 3 bits and never wraps past 7. cnt is 8 bits and saturates at the parameter bound.
// STRUCTURE
//  Shared package truth_sweep_pkg holds:
//   state enum {IDLE,SETTLE,SAMPLE,DONE}; localparam ROWS=8;
//   function tt_bit(row) = 7-row; the row-to-bit mapping shared with the compiler's truth-table models.
//  Sub-module bit_sync2: 2-flop synchroniser for dut_out, with async active-low reset to 0.
//  The FSM, counters and result registers live in this module.
// TESTING  (SETTLE_CYCLES=4, SAMPLE_CYCLES=2, DUT = 0x0C function)
//  expected=8'h0C, start pulse -> pins walk 000..111, 6 cycles each; done in cycle T+49;
//   measured=0C, match=1, mismatch_mask=00.
//  expected=8'h0D -> measured=0C, mismatch_mask=01, match=0.
//  dut_out toggled in the 2nd sample cycle of row 5 -> unstable=8'h04, match=0.
//  abort during SETTLE of row 3 -> aborted pulse; pins 000 the next cycle; no done; busy=0.
//  start re-pulsed at row 2 -> ignored; sweep timing and results unchanged.
//  rst_n low during SAMPLE of row 6 -> all outputs 0 at once; a new start afterwards completes normally.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// Shared types and row-to-bit mapping for the truth-table sweeper.
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int unsigned ROWS = 8;

    // Wolfram coding: row r = {in1,in2,in3} lands in bit 7-r.
    function automatic logic [2:0] tt_bit(input logic [2:0] row);
        return 3'(ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module bit_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages reset to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input rows of a 3-input function, samples its output per row,
// and reports the captured Wolfram code against an expected code.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [7:0] measured,
    output logic [7:0] mismatch_mask,
    output logic [7:0] unstable,
    output logic       match
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [2:0] LAST_ROW    = 3'(ROWS - 1);

    sweep_state_t state_q, state_d;

    logic [2:0] row_q;
    logic [7:0] cnt_q;
    logic [7:0] expected_q;
    logic       sync_out;

    // Control strobes from the FSM to the datapath.
    logic       load;
    logic       take_abort;
    logic       finish;
    logic       adv_row;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       sample_en;
    logic       drive;

    logic [7:0] measured_d;
    logic [7:0] unstable_d;

    bit_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (sync_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control strobes; abort outranks the count-driven moves.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        take_abort = 1'b0;
        finish     = 1'b0;
        adv_row    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        sample_en  = 1'b0;
        drive      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                drive = 1'b1;
                if (abort) begin
                    take_abort = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = SAMPLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SAMPLE: begin
                drive = 1'b1;
                if (abort) begin
                    take_abort = 1'b1;
                    state_d    = IDLE;
                end else begin
                    sample_en = 1'b1;
                    if (cnt_q == SAMPLE_LAST) begin
                        if (row_q == LAST_ROW) begin
                            finish  = 1'b1;
                            state_d = DONE;
                        end else begin
                            adv_row = 1'b1;
                            cnt_clr = 1'b1;
                            state_d = SETTLE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result capture: first sample sets the row bit, later disagreeing samples flag it unstable.
    always_comb begin
        measured_d = measured;
        unstable_d = unstable;
        if (load) begin
            measured_d = '0;
            unstable_d = '0;
        end else if (sample_en) begin
            if (cnt_q == '0) begin
                measured_d[tt_bit(row_q)] = sync_out;
            end else if (sync_out != measured[tt_bit(row_q)]) begin
                unstable_d[tt_bit(row_q)] = 1'b1;
            end
        end
    end

    // Datapath registers; comparison uses the same-edge capture so results are valid in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= '0;
            cnt_q         <= '0;
            expected_q    <= '0;
            measured      <= '0;
            unstable      <= '0;
            mismatch_mask <= '0;
            match         <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            measured <= measured_d;
            unstable <= unstable_d;
            done     <= finish;
            aborted  <= take_abort;

            if (load) begin
                expected_q    <= expected;
                row_q         <= '0;
                cnt_q         <= '0;
                mismatch_mask <= '0;
                match         <= 1'b0;
            end else begin
                if (adv_row) row_q <= row_q + 3'd1;
                if (cnt_clr) begin
                    cnt_q <= '0;
                end else if (cnt_inc && (cnt_q != 8'hFF)) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                if (finish) begin
                    mismatch_mask <= measured_d ^ expected_q;
                    match         <= (measured_d == expected_q) && (unstable_d == '0);
                end
            end
        end
    end

    // Row drive and status decode.
    always_comb begin
        {in1, in2, in3} = drive ? row_q : 3'b000;
        busy            = (state_q != IDLE);
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboarded bench: stimulus pushes expected results, a monitor checks each done/aborted pulse.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       in1, in2, in3;
    logic       dut_out;
    logic       busy, done, aborted;
    logic [7:0] measured, mismatch_mask, unstable;
    logic       match;

    logic [7:0] func_code = 8'h0C;
    logic       glitch;
    logic [2:0] pins;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] kind;   // {done, aborted}
        int         cyc;
        logic [7:0] meas;
        logic [7:0] mm;
        logic [7:0] unst;
        logic       mt;
    } exp_t;

    exp_t sb[$];

    truth_table_sweeper #(
        .SETTLE_CYCLES (4),
        .SAMPLE_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .expected      (expected),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .measured      (measured),
        .mismatch_mask (mismatch_mask),
        .unstable      (unstable),
        .match         (match)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pins    = {in1, in2, in3};
    assign dut_out = func_code[3'd7 - pins] ^ glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic push_exp(input logic [1:0] kind, input int c, input logic [7:0] meas,
                            input logic [7:0] mm, input logic [7:0] unst, input logic mt);
        exp_t e;
        e.kind = kind; e.cyc = c; e.meas = meas; e.mm = mm; e.unst = unst; e.mt = mt;
        sb.push_back(e);
    endtask

    // Pulse start for one cycle, then scramble expected to show only the latched copy matters.
    task automatic run_start(input logic [7:0] code, input logic ab);
        start    = 1'b1;
        abort    = ab;
        expected = code;
        tick(1);
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'hA5;
    endtask

    // Monitor: every result pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (done || aborted)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%0b aborted=%0b, required no pulse (cyc %0d)",
                         done, aborted, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'd0, done, aborted}, {30'd0, e.kind});
                check("pulse_cycle", cyc, e.cyc);
                check("measured", {24'd0, measured}, {24'd0, e.meas});
                check("mismatch_mask", {24'd0, mismatch_mask}, {24'd0, e.mm});
                check("unstable", {24'd0, unstable}, {24'd0, e.unst});
                check("match", {31'd0, match}, {31'd0, e.mt});
            end
        end
    end

    initial begin
        int c;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'h00;
        glitch   = 1'b0;
        tick(3);

        // Reset state.
        check("rst_outputs", {busy, done, aborted, match, pins},  8'h00);
        check("rst_results", {8'h0, measured, mismatch_mask, unstable}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Clean sweep, row walk and completion timing.
        c = cyc;
        push_exp(2'b10, c + 49, 8'h0C, 8'h00, 8'h00, 1'b1);
        run_start(8'h0C, 1'b0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int r = 0; r < 8; r++) begin
            goto(c + 1 + 6 * r);
            check("row_first", {29'd0, pins}, r);
            goto(c + 6 + 6 * r);
            check("row_last", {29'd0, pins}, r);
        end
        goto(c + 50);
        check("idle_after_done", {busy, done, pins}, 5'b0);
        check("result_hold", {23'd0, match, measured}, {23'd0, 1'b1, 8'h0C});
        tick(2);

        // Wrong expected code, with abort coincident with start (start wins).
        c = cyc;
        push_exp(2'b10, c + 49, 8'h0C, 8'h01, 8'h00, 1'b0);
        run_start(8'h0D, 1'b1);
        goto(c + 52);

        // Glitch landing in the second synchronised sample of row 5; abort in DONE ignored.
        c = cyc;
        push_exp(2'b10, c + 49, 8'h0C, 8'h00, 8'h04, 1'b0);
        run_start(8'h0C, 1'b0);
        goto(c + 34);
        glitch = 1'b1;
        tick(1);
        glitch = 1'b0;
        goto(c + 49);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        goto(c + 52);

        // Abort during SETTLE of row 3.
        c = cyc;
        push_exp(2'b01, c + 21, 8'h00, 8'h00, 8'h00, 1'b0);
        run_start(8'h0C, 1'b0);
        goto(c + 20);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_idle", {busy, done, pins}, 5'b0);
        goto(c + 55);

        // Start re-pulsed at row 2 with a different code: ignored.
        c = cyc;
        push_exp(2'b10, c + 49, 8'h0C, 8'h00, 8'h00, 1'b1);
        run_start(8'h0C, 1'b0);
        goto(c + 13);
        start    = 1'b1;
        expected = 8'hFF;
        tick(1);
        start    = 1'b0;
        goto(c + 52);

        // Async reset during SAMPLE of row 6, then a fresh sweep.
        c = cyc;
        run_start(8'h0C, 1'b0);
        goto(c + 41);
        check("pre_reset_partial", {24'd0, measured}, 32'h0C);
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {busy, done, aborted, match, pins}, 8'h00);
        check("reset_results", {8'h0, measured, mismatch_mask, unstable}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        c = cyc;
        push_exp(2'b10, c + 49, 8'h0C, 8'h00, 8'h00, 1'b1);
        run_start(8'h0C, 1'b0);
        goto(c + 55);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
